// File: rtl/crc9_128_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc9_128_encoder_if
//  Description : Data-in / codeword-out bundle for the CRC-9 encoder.
//                master = producer of data words and consumer of codewords,
//                slave  = the encoder itself.
//                  enable  : 1 = i_data is accepted this cycle
//                  i_data  : data word, [0] is the MSB, first into the CRC
//                  o_code  : registered codeword {data, crc9}
//                  o_valid : 1 = o_code holds the word accepted last edge
//  Revision    : 1.0  initial release
// ============================================================================
interface crc9_128_encoder_if #(
    parameter int DATA_W = 128
);
    localparam int CODE_W = DATA_W + 9;

    logic              enable;
    logic [0:DATA_W-1] i_data;
    logic [0:CODE_W-1] o_code;
    logic              o_valid;

    modport master (
        output enable,
        output i_data,
        input  o_code,
        input  o_valid
    );

    modport slave (
        input  enable,
        input  i_data,
        output o_code,
        output o_valid
    );
endinterface
`default_nettype wire

// File: rtl/crc9_128_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : crc9_128_encoder
//  Description : Systematic CRC-9 encoder, one 128-bit word per clock.
//                Registers the codeword {data, crc9}; data field first, the
//                nine check bits last (o_code[128] = x^8 ... o_code[136] = x^0).
//                CRC: remainder of M(x)*x^9 / G(x), init 0, MSB-first,
//                no reflection, no final XOR.
//  Ports       : clk     - rising-edge clock
//                reset_n - synchronous reset, asserted HIGH despite the name
//                bus     - crc9_128_encoder_if.slave (enable, i_data,
//                          o_code, o_valid)
//  Revision    : 1.0  initial release
// ============================================================================
module crc9_128_encoder #(
    parameter int         DATA_W = 128,
    parameter logic [8:0] POLY   = 9'h031   // low terms of G, x^9 implied
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    crc9_128_encoder_if.slave        bus
);

    localparam int C_CODE_W = DATA_W + 9;

    // Serial LFSR fully unrolled across the word: each step shifts the
    // remainder left and folds in the generator when the bit leaving x^8
    // differs from the incoming data bit. data[0] enters first.
    function automatic logic [8:0] f_crc9(input logic [0:DATA_W-1] data);
        logic [8:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            fb  = crc[8] ^ data[i];
            crc = {crc[7:0], 1'b0};
            if (fb) begin
                crc = crc ^ POLY;
            end
        end
        return crc;
    endfunction

    logic [8:0]          w_crc;
    logic [0:C_CODE_W-1] w_code_d;
    logic [0:C_CODE_W-1] r_code_q;
    logic                w_valid_d;
    logic                r_valid_q;

    // Next-state: an enabled cycle loads a fresh codeword; otherwise the
    // codeword is held and the valid flag drops.
    always_comb begin
        w_crc     = f_crc9(bus.i_data);
        w_code_d  = r_code_q;
        w_valid_d = 1'b0;
        if (bus.enable) begin
            w_code_d  = {bus.i_data, w_crc};
            w_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_code_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_code_q  <= w_code_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign bus.o_code  = r_code_q;
    assign bus.o_valid = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_crc9_128_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc9_128_encoder
//  Description : Self-checking bench for crc9_128_encoder. Each applied cycle
//                pushes the expected {valid, codeword} into a scoreboard; after
//                the edge the entry is popped and compared against the DUT.
//                The reference CRC is plain polynomial long division.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crc9_128_encoder;

    typedef struct packed {
        logic         v;
        logic [136:0] code;
    } exp_t;

    logic clk;
    logic reset_n;

    crc9_128_encoder_if #(.DATA_W(128)) bus ();

    crc9_128_encoder #(
        .DATA_W (128),
        .POLY   (9'h031)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp;
    int           n_err;
    exp_t         sb[$];
    logic [136:0] m_code;    // model of the held codeword register

    // Long division of {d, 9'b0} by G = x^9+x^5+x^4+1; the MSB of d is the
    // highest-order term.
    function automatic logic [8:0] model_crc(input logic [127:0] d);
        logic [136:0] m;
        m = {d, 9'b0};
        for (int i = 136; i >= 9; i--) begin
            if (m[i]) begin
                m[i -: 10] = m[i -: 10] ^ 10'h231;
            end
        end
        return m[8:0];
    endfunction

    task automatic check(input string tag, input logic [136:0] got, input logic [136:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push its expectation, clock it, then pop and compare.
    task automatic step(input logic rst, input logic en, input logic [127:0] d);
        exp_t e;
        reset_n    = rst;
        bus.enable = en;
        bus.i_data = d;
        if (rst) begin
            m_code = '0;
            e.v    = 1'b0;
        end else if (en) begin
            m_code = {d, model_crc(d)};
            e.v    = 1'b1;
        end else begin
            e.v    = 1'b0;
        end
        e.code = m_code;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 137'd1, 137'd0);
        end else begin
            e = sb.pop_front();
            check("valid", {136'd0, bus.o_valid}, {136'd0, e.v});
            check("code", bus.o_code, e.code);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [127:0] burst [4];

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        m_code     = '0;
        reset_n    = 1'b1;
        bus.enable = 1'b0;
        bus.i_data = '0;
        burst[0]   = 128'hb4705b94;
        burst[1]   = 128'hb35ae135;
        burst[2]   = 128'hf4631f09;
        burst[3]   = 128'h5f9254db;

        // Reset held with enable high and random data: outputs stay zero.
        step(1'b1, 1'b1, rand128());
        step(1'b1, 1'b1, rand128());
        check("rst_code", bus.o_code, 137'd0);
        // First enabled edge after release produces a valid word.
        step(1'b0, 1'b1, rand128());

        // All-zero word gives an all-zero codeword.
        step(1'b0, 1'b1, 128'h0);
        check("zero_code", bus.o_code, 137'd0);

        // Single-bit and two-bit words against known remainders.
        step(1'b0, 1'b1, 128'h1);
        check("crc_h1", {128'd0, bus.o_code[128:136]}, {128'd0, 9'h031});
        step(1'b0, 1'b1, 128'h2);
        check("crc_h2", {128'd0, bus.o_code[128:136]}, {128'd0, 9'h062});
        step(1'b0, 1'b1, 128'h3);
        check("crc_h3", {128'd0, bus.o_code[128:136]}, {128'd0, 9'h053});
        check("echo_h3", {9'd0, bus.o_code[0:127]}, {9'd0, 128'h3});
        // Top bit (first into the register) exercises the full unroll.
        step(1'b0, 1'b1, {1'b1, 127'd0});

        // Back-to-back burst, then a 3-cycle enable gap, then resume.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, burst[i]);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rand128());
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, burst[3 - i]);

        // Random stream with occasional idle cycles and one reset pulse.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                step(1'b1, 1'b1, rand128());
            end else begin
                step(1'b0, ($urandom_range(0, 7) != 0), rand128());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
